// File: rtl/mul_arb_pkg.sv
// Shared constants for the multiplier arbiter: FSM state encodings and default sizing.
package mul_arb_pkg;

  localparam int NUM_REQ_D = 4;
  localparam int W_D       = 4;
  localparam int ID_W_D    = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/mul_arb_if.sv
// Request/response bundle between client blocks (master) and the multiplier arbiter (slave).
interface mul_arb_if #(
  parameter int NUM_REQ = mul_arb_pkg::NUM_REQ_D,
  parameter int W       = mul_arb_pkg::W_D,
  parameter int ID_W    = mul_arb_pkg::ID_W_D
) ();

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic [2*W-1:0]       rsp_y;
  logic                 rsp_ready;
  logic                 busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, busy
  );

endinterface

// File: rtl/mul.sv
// Existing signed combinational multiplier datapath, full-width product.
module mul #(
  parameter int W = 4
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] y
);

  assign y = a * b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // scan from ptr upward; the first hit masks every later candidate
  always_comb begin
    logic [ID_W-1:0] j_s;
    logic            hit_s;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    j_s   = '0;
    hit_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j_s      = ID_W'((int'(ptr) + i) % NUM_REQ);
      hit_s    = req[j_s] & ~any;
      gnt[j_s] = gnt[j_s] | hit_s;
      idx      = hit_s ? j_s : idx;
      any      = any | hit_s;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin sharing of one signed multiplier among NUM_REQ requesters.
// IDLE grants and captures operands, MUL registers the product, RESP holds it until accepted.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int W       = W_D,
  parameter int ID_W    = ID_W_D
) (
  input logic        clk,
  input logic        rst_n,
  mul_arb_if.slave   bus
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    cur_id_r;
  logic [W-1:0]       op_a_r;
  logic [W-1:0]       op_b_r;
  logic [2*W-1:0]     rsp_y_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic               rsp_valid_r;
  logic               busy_r;

  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    idx_s;
  logic               any_s;
  logic [NUM_REQ-1:0] req_ready_s;
  logic [2*W-1:0]     prod_s;
  logic [W-1:0]       a_arr_s [NUM_REQ];
  logic [W-1:0]       b_arr_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr_s[gi] = bus.req_a[gi*W +: W];
    assign b_arr_s[gi] = bus.req_b[gi*W +: W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (idx_s),
    .any (any_s)
  );

  mul #(
    .W (W)
  ) u_mul (
    .a (op_a_r),
    .b (op_b_r),
    .y (prod_s)
  );

  // grants are only offered while idle so a stalled response never admits new work
  always_comb begin
    req_ready_s = '0;
    if (state_r == ST_IDLE) begin
      req_ready_s = gnt_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // sequencing: grant/capture, product registration, response hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= '0;
      cur_id_r    <= '0;
      op_a_r      <= '0;
      op_b_r      <= '0;
      rsp_y_r     <= '0;
      rsp_id_r    <= '0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            op_a_r   <= a_arr_s[idx_s];
            op_b_r   <= b_arr_s[idx_s];
            cur_id_r <= idx_s;
            ptr_r    <= (idx_s == LAST_ID) ? '0 : idx_s + ID_W'(1);
            state_r  <= ST_MUL;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_MUL: begin
          rsp_y_r     <= prod_s;
          rsp_id_r    <= cur_id_r;
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_y     = rsp_y_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_mul_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mul_arb_if #(.NUM_REQ(4), .W(4), .ID_W(2)) bus ();

  mul_arbiter #(.NUM_REQ(4), .W(4), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits (bounded) for its response and accepts it.
  task automatic send_one(input int id, input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] gr, output logic [1:0] rid,
                          output logic [7:0] ry, output int lat, output bit ok);
    logic [3:0] v;
    v = '0;
    v[id] = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = v;
    bus.req_a[id*4 +: 4] = a;
    bus.req_b[id*4 +: 4] = b;
    @(negedge clk);
    gr = bus.req_ready;
    @(posedge clk);
    #1 bus.req_valid = '0;
    ok = 1'b0; rid = '0; ry = '0; lat = -1;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1; rid = bus.rsp_id; ry = bus.rsp_y; lat = k;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.busy} !== 16'h0000) begin
        errors++;
        $display("FAIL reset_outputs: cycle %0d got ready=%b valid=%b id=%0d y=%h busy=%b, required all 0",
                 c, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.busy);
      end
      checks++;
      if (dut.ptr_r !== 2'd0) begin
        errors++;
        $display("FAIL reset_ptr: got %0d required 0", dut.ptr_r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [3:0] gr; logic [1:0] rid; logic [7:0] ry; int lat; bit ok;
    send_one(2, 4'd3, 4'd5, gr, rid, ry, lat, ok);
    checks++;
    if (gr !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b required 0100", gr); end
    checks++;
    if (!ok || lat != 1) begin errors++; $display("FAIL single_latency: got ok=%0d lat=%0d required ok=1 lat=1", ok, lat); end
    checks++;
    if (rid !== 2'd2 || ry !== 8'd15) begin errors++; $display("FAIL single_result: got id=%0d y=%0d required id=2 y=15", rid, ry); end
  endtask

  task automatic test_signed_corners();
    logic [3:0] ca [4] = '{4'h8, 4'h8, 4'hF, 4'h0};
    logic [3:0] cb [4] = '{4'h8, 4'h7, 4'h1, 4'hB};
    logic [7:0] cy [4] = '{8'h40, 8'hC8, 8'hFF, 8'h00};
    logic [3:0] gr; logic [1:0] rid; logic [7:0] ry; int lat; bit ok;
    for (int i = 0; i < 4; i++) begin
      send_one(i, ca[i], cb[i], gr, rid, ry, lat, ok);
      checks++;
      if (!ok || rid !== 2'(i) || ry !== cy[i]) begin
        errors++;
        $display("FAIL signed_corner_%0d: got ok=%0d id=%0d y=%h required id=%0d y=%h", i, ok, rid, ry, i, cy[i]);
      end
    end
  endtask

  task automatic test_fairness();
    int ngr = 0;
    int nrsp = 0;
    logic [1:0] eid;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*4 +: 4] = 4'(i + 1);
      bus.req_b[i*4 +: 4] = 4'd2;
    end
    bus.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 60 && nrsp < 5; cyc++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0000) ngr++;
      if (bus.rsp_valid) begin
        eid = 2'(nrsp % 4);
        checks++;
        if (bus.rsp_id !== eid || bus.rsp_y !== 8'(2 * (int'(eid) + 1))) begin
          errors++;
          $display("FAIL fairness_rsp_%0d: got id=%0d y=%0d required id=%0d y=%0d",
                   nrsp, bus.rsp_id, bus.rsp_y, eid, 2 * (int'(eid) + 1));
        end
        nrsp++;
      end
      @(posedge clk);
      #1;
      if (ngr >= 5) bus.req_valid = '0;
    end
    checks++;
    if (nrsp != 5) begin errors++; $display("FAIL fairness_count: got %0d responses required 5", nrsp); end
  endtask

  task automatic test_backpressure();
    logic [3:0] a1, b1, a3, b3;
    logic [7:0] ey1, ey3;
    bit seen;
    a1 = 4'($urandom); b1 = 4'($urandom); a3 = 4'($urandom); b3 = 4'($urandom);
    ey1 = 8'(int'($signed(a1)) * int'($signed(b1)));
    ey3 = 8'(int'($signed(a3)) * int'($signed(b3)));
    bus.rsp_ready = 1'b0;
    bus.req_a[4 +: 4] = a1;  bus.req_b[4 +: 4] = b1;
    bus.req_a[12 +: 4] = a3; bus.req_b[12 +: 4] = b3;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant: got %b required 0010", bus.req_ready); end
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_timeout: got no rsp_valid required rsp_valid=1"); end
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_y !== ey1 || bus.req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b id=%0d y=%h ready=%b required valid=1 id=1 y=%h ready=0000",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.req_ready, ey1);
      end
    end
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: got busy=%b ready=%b required busy=0 ready=1000", bus.busy, bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    checks++;
    if (!seen || bus.rsp_id !== 2'd3 || bus.rsp_y !== ey3) begin
      errors++;
      $display("FAIL bp_next_rsp: got valid=%b id=%0d y=%h required valid=1 id=3 y=%h", seen, bus.rsp_id, bus.rsp_y, ey3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_mul();
    bit seen;
    bus.rsp_ready = 1'b1;
    bus.req_a[4 +: 4] = 4'd6;
    bus.req_b[4 +: 4] = 4'd3;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rmul_grant: got %b required 0010", bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rmul_async: got valid=%b busy=%b required 0 0", bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen = seen | bus.rsp_valid;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rmul_no_rsp: got rsp_valid=1 required 0"); end
    @(posedge clk);
    #1 bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmul_ptr: got %b required 0001", bus.req_ready); end
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Transaction-level model: one job in flight, result visible from one edge after the accept edge.
  task automatic test_random();
    int m_ptr = 0;
    bit m_busy = 1'b0;
    int m_age = 0;
    int m_id = 0;
    logic [7:0] m_y = '0;
    int g;
    int j;
    logic [3:0] exp_ready;
    bit exp_valid;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.req_valid = 4'($urandom_range(0, 15));
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = -1;
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (g < 0 && bus.req_valid[j]) g = j;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_valid = m_busy && (m_age >= 1);
      checks++;
      if (bus.req_ready !== exp_ready || bus.rsp_valid !== exp_valid || bus.busy !== m_busy) begin
        errors++;
        $display("FAIL rand_ctrl: cycle %0d got ready=%b valid=%b busy=%b required ready=%b valid=%b busy=%b",
                 cyc, bus.req_ready, bus.rsp_valid, bus.busy, exp_ready, exp_valid, m_busy);
      end
      if (exp_valid) begin
        checks++;
        if (bus.rsp_id !== 2'(m_id) || bus.rsp_y !== m_y) begin
          errors++;
          $display("FAIL rand_data: cycle %0d got id=%0d y=%h required id=%0d y=%h",
                   cyc, bus.rsp_id, bus.rsp_y, m_id, m_y);
        end
      end
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1'b1;
          m_age  = 0;
          m_id   = g;
          m_y    = 8'(int'($signed(bus.req_a[g*4 +: 4])) * int'($signed(bus.req_b[g*4 +: 4])));
          m_ptr  = (g + 1) % 4;
        end
      end else if (m_age >= 1 && bus.rsp_ready) begin
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_single();
    test_signed_corners();
    test_fairness();
    test_backpressure();
    test_reset_in_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one signed combinational multiplier among NUM_REQ independent requesters. Arbitration is round-robin with a per-requester valid/ready operand handshake and a single valid/ready response channel tagged with the requester index. It sits between client blocks and the existing `mul` datapath and owns all sequencing: grant, operand capture, result registration and back-pressure.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- W, 4: operand width; operands are signed two's complement.
- ID_W, 2: width of requester index; must equal clog2(NUM_REQ).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i presents operands.
- req_a  input  NUM_REQ*W  packed; slice i = signed operand a of requester i.
- req_b  input  NUM_REQ*W  packed; slice i = signed operand b of requester i.
- req_ready  output  NUM_REQ  one-hot or zero; bit i high means requester i is granted this cycle.
- rsp_valid  output  1  result available.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_y  output  2*W  signed product a*b.
- rsp_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Three-state FSM:
  - IDLE: the arbiter picks a winner among req_valid. req_ready[winner] is asserted combinationally; no other bit is asserted. On the edge, operands of the winner are latched into op_a/op_b, the winner is latched into cur_id, and the FSM moves to MUL. With no request pending, the FSM stays in IDLE.
  - MUL: op_a/op_b drive the multiplier. On the edge, the product is registered into rsp_y, cur_id into rsp_id, and the FSM moves to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1 on an edge, the FSM returns to IDLE. Otherwise rsp_y and rsp_id hold unchanged.
- req_ready is 0 in MUL and RESP.
- Round-robin rule:
  - A pointer ptr holds the highest-priority index. The search order is ptr, ptr+1, … modulo NUM_REQ.
  - After a grant to index g, ptr becomes (g+1) mod NUM_REQ.
  - ptr is unchanged when nothing is granted.
- Arithmetic: full signed product, 2*W bits, with no truncation. The range is -(2^(W-1))*(2^(W-1)-1) to 2^(2W-2), and this always fits.
- req_a/req_b are sampled only on the accepting edge. Changes afterwards do not affect the result.
- A requester that drops req_valid before being granted is simply skipped. No state is kept per requester.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, state=IDLE, ptr=0, op_a=op_b=0.
- Latency: accept edge E0, then rsp_valid goes high after E0+1 edge (i.e., visible the cycle following MUL). Two edges from accept to valid result.
- Throughput: one transaction per 3 cycles when rsp_ready is held high. A held rsp_ready=0 stalls indefinitely, with no loss and no new grant.
- Simultaneous events:
  - All requesters valid gives grants in order ptr, ptr+1, …; no requester waits more than NUM_REQ transactions.
  - A single valid requester gets back-to-back grants every 3 cycles.
- Reset mid-operation: asynchronous return to IDLE and reset values. The in-flight transaction is discarded and no response is produced.
- rsp_valid, once asserted, stays high with stable rsp_y/rsp_id until accepted.

## Structure
- Shared package mul_arb_pkg holds:
  - state encodings: IDLE=2'd0, MUL=2'd1, RESP=2'd2;
  - default NUM_REQ, W and ID_W constants.
- Sub-module rr_arbiter, combinational: takes req vector and ptr, returns a one-hot grant and an encoded index.
- The existing `mul` module is instantiated unmodified as the datapath, sized by W.

## Test plan
- Reset: rst_n low, then release with all inputs 0 → all outputs 0, busy=0, ptr=0 for 5 cycles.
- Single request: requester 2 sends a=3, b=5, rsp_ready=1 → req_ready=4'b0100 for one cycle; 2 edges later rsp_valid=1, rsp_id=2, rsp_y=15.
- Signed corners, each with a separate requester:
  - a=-8, b=-8 → rsp_y=64.
  - a=-8, b=7 → rsp_y=-56.
  - a=-1, b=1 → rsp_y=-1.
  - a=0, b=-5 → rsp_y=0.
- Fairness: all four requesters hold valid with a=i+1, b=2 → responses in id order 0,1,2,3,0 with rsp_y 2,4,6,8,2. No id repeats before all four have been served.
- Back-pressure: rsp_ready held 0 for 6 cycles after rsp_valid → rsp_y/rsp_id stable, req_ready stays 0. One cycle after rsp_ready=1 the FSM is in IDLE and the next grant goes to ptr.
- Reset in MUL: assert rst_n low during MUL for requester 1 → no rsp_valid ever appears for that request, and after release the first grant follows ptr=0.
